// File: rtl/flex_cnt_pkg.sv
// Shared types and constants for the flex_counter_ext slice: counting mode
// encoding used by the top and the next-count sub-module.
package flex_cnt_pkg;

  localparam logic MODE_WRAP_ENC = 1'b0;
  localparam logic MODE_SAT_ENC  = 1'b1;

  typedef enum logic {
    MODE_WRAP = MODE_WRAP_ENC,
    MODE_SAT  = MODE_SAT_ENC
  } cnt_mode_t;

endpackage

// File: rtl/flex_cnt_next.sv
// Combinational next-count for an enabled cycle: add step without truncation,
// clamp to rollover_i, then wrap to WRAP_VAL or saturate once at the terminal.
module flex_cnt_next
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 32,
  parameter int STEP_BITS    = 8,
  parameter int WRAP_VAL     = 1
) (
  input  logic [NUM_CNT_BITS-1:0] count_i,
  input  logic [STEP_BITS-1:0]    step_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_i,
  input  logic                    mode_i,
  output logic [NUM_CNT_BITS-1:0] next_o
);

  localparam int SUM_W = NUM_CNT_BITS + 1;
  localparam logic [NUM_CNT_BITS-1:0] WRAP_N = NUM_CNT_BITS'(WRAP_VAL);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum    = SUM_W'(count_i) + SUM_W'(step_i);
    next_o = count_i;
    // A zero terminal pins the count at zero in both modes.
    if (rollover_i == '0) begin
      next_o = '0;
    end else if (count_i < rollover_i) begin
      next_o = (sum >= SUM_W'(rollover_i)) ? rollover_i : sum[NUM_CNT_BITS-1:0];
    end else if (cnt_mode_t'(mode_i) == MODE_WRAP) begin
      next_o = WRAP_N;
    end else begin
      next_o = rollover_i;
    end
  end

endmodule

// File: rtl/flex_counter_ext.sv
// Step counter with wrap/saturate modes, level and pulse rollover flags and an
// optional saturating wrap counter (compiled in with FLEX_CNT_WRAPCNT_EN).
module flex_counter_ext
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS  = 32,
  parameter int STEP_BITS     = 8,
  parameter int WRAP_VAL      = 1,
  parameter int WRAP_CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [STEP_BITS-1:0]     step,
  input  logic                     mode,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     rollover_pulse,
  output logic [WRAP_CNT_BITS-1:0] wrap_count
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d, next_cnt;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;

  flex_cnt_next #(
    .NUM_CNT_BITS (NUM_CNT_BITS),
    .STEP_BITS    (STEP_BITS),
    .WRAP_VAL     (WRAP_VAL)
  ) u_next (
    .count_i    (count_q),
    .step_i     (step),
    .rollover_i (rollover_val),
    .mode_i     (mode),
    .next_o     (next_cnt)
  );

  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      flag_d  = (load_val == rollover_val);
    end else if (count_enable) begin
      count_d = next_cnt;
      flag_d  = (next_cnt == rollover_val);
      pulse_d = (count_q != rollover_val) && (next_cnt == rollover_val);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;

`ifdef FLEX_CNT_WRAPCNT_EN
  logic [WRAP_CNT_BITS-1:0] wrap_q, wrap_d;
  logic                     wrap_ev;

  // Mirrors the wrap branch of flex_cnt_next so the default build carries no wrap logic.
  assign wrap_ev = !clear && !load && count_enable && (rollover_val != '0) &&
                   (count_q >= rollover_val) && (cnt_mode_t'(mode) == MODE_WRAP);

  always_comb begin
    wrap_d = wrap_q;
    if (clear) begin
      wrap_d = '0;
    end else if (wrap_ev && (wrap_q != '1)) begin
      wrap_d = wrap_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_count = wrap_q;
`else
  assign wrap_count = {WRAP_CNT_BITS{1'b0}};
`endif

endmodule
